// File: rtl/pipe_skid_reg.sv
// Elastic pipeline register with a two-entry skid buffer, flush and NOP bubbles.
// Define PIPE_SKID_PERF_EN to build the saturating stall/bubble counters.
module pipe_skid_reg #(
  parameter int unsigned DW = 128,
  parameter logic [DW-1:0] NOP_VALUE = '0,
  parameter int unsigned CW = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  input  logic          flush,
  output logic [1:0]    occupancy,
  input  logic          perf_clr,
  output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [DW-1:0] main_q, main_n;
  logic [DW-1:0] skid_q, skid_n;
  logic          rdy_q;
  logic          accept, consume;

  assign accept = in_valid & rdy_q;
  assign consume = out_valid & out_ready;

  // Encoding doubles as the occupancy count.
  assign occupancy = state;
  assign out_valid = (state != EMPTY);
  assign out_data = main_q;
  assign in_ready = rdy_q;

  always_comb begin
    state_n = state;
    main_n = main_q;
    skid_n = skid_q;
    if (flush) begin
      state_n = EMPTY;
      main_n = NOP_VALUE;
      skid_n = NOP_VALUE;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_n = ONE;
            main_n = in_data;
          end
        end
        ONE: begin
          unique case (1'b1)
            accept & consume: main_n = in_data;
            accept & !consume: begin
              state_n = FULL;
              skid_n = in_data;
            end
            !accept & consume: begin
              state_n = EMPTY;
              main_n = NOP_VALUE;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (consume) begin
            state_n = ONE;
            main_n = skid_q;
          end
        end
        default: begin
          state_n = EMPTY;
          main_n = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= EMPTY;
      main_q <= NOP_VALUE;
      skid_q <= NOP_VALUE;
      rdy_q <= 1'b1;
    end else begin
      state <= state_n;
      main_q <= main_n;
      skid_q <= skid_n;
      rdy_q <= (state_n != FULL);
    end
  end

`ifdef PIPE_SKID_PERF_EN
  logic [CW-1:0] stall_q, bubble_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_q <= '0;
      bubble_q <= '0;
    end else if (perf_clr) begin
      stall_q <= '0;
      bubble_q <= '0;
    end else begin
      if (out_valid && !out_ready && !(&stall_q))
        stall_q <= stall_q + CW'(1);
      if (!out_valid && out_ready && !(&bubble_q))
        bubble_q <= bubble_q + CW'(1);
    end
  end

  assign stall_cnt = stall_q;
  assign bubble_cnt = bubble_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign stall_cnt = '0;
  assign bubble_cnt = '0;
`endif

endmodule
